// File: rtl/sort_engine_param.sv
// In-place bubble sorter over a DEPTH-word register array, with ascending/descending
// order, early exit on a swap-free pass, and swap/pass statistics for the last sort.
module sort_engine_param #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    parameter  int CNT_W  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              descend,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  swap_cnt,
    output logic [ADDR_W:0]   pass_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_CMP, S_SWP, S_ADV, S_PEND, S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   op_a, op_b;
    logic [ADDR_W-1:0]   j, lim, j_nxt;
    logic                desc, swapped, ooo, host_wr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign j_nxt   = j + ADDR_W'(1);
    // Strict compare keeps equal elements in place, so the sort is stable.
    assign ooo     = desc ? (op_a < op_b) : (op_a > op_b);
    assign busy    = (state != S_IDLE) && (state != S_DONE);
    assign done    = (state == S_DONE);
    assign host_wr = wr_en && !busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RD;
            S_RD:    state_nxt = S_CMP;
            S_CMP:   state_nxt = ooo ? S_SWP : S_ADV;
            S_SWP:   state_nxt = S_ADV;
            S_ADV:   state_nxt = (j == lim) ? S_PEND : S_RD;
            S_PEND:  state_nxt = (!swapped || lim == '0) ? S_DONE : S_RD;
            S_DONE:  if (!start) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            desc     <= 1'b0;
            j        <= '0;
            lim      <= '0;
            swapped  <= 1'b0;
            swap_cnt <= '0;
            pass_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    desc     <= descend;
                    j        <= '0;
                    lim      <= ADDR_W'(DEPTH - 2);
                    swapped  <= 1'b0;
                    swap_cnt <= '0;
                    pass_cnt <= '0;
                end
                S_SWP: begin
                    swapped  <= 1'b1;
                    swap_cnt <= sat_inc(swap_cnt);
                end
                S_ADV: if (j != lim) j <= j_nxt;
                S_PEND: begin
                    pass_cnt <= pass_cnt + (ADDR_W+1)'(1);
                    if (swapped && lim != '0) begin
                        lim     <= lim - ADDR_W'(1);
                        j       <= '0;
                        swapped <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Array and operands carry no reset; a reset mid-sort leaves the array as it was.
    always_ff @(posedge clk) begin
        if (state == S_RD) begin
            op_a <= mem[j];
            op_b <= mem[j_nxt];
        end
        if (state == S_SWP) begin
            mem[j]     <= op_b;
            mem[j_nxt] <= op_a;
        end else if (host_wr) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= '0;
        else        rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_sort_engine_param.sv
// Scoreboard bench for sort_engine_param: stimulus pushes expected statistics and
// read-back words into queues; a monitor pops and compares when the DUT presents them.
module tb_sort_engine_param;

    localparam int DW = 8;
    localparam int N  = 16;
    localparam int AW = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, descend = 1'b0, wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data;
    logic          busy, done;
    logic [CW-1:0] swap_cnt;
    logic [AW:0]   pass_cnt;

    sort_engine_param #(.DATA_W(DW), .DEPTH(N), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .descend(descend),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
        .swap_cnt(swap_cnt), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] sw;
        logic [AW:0]   pc;
    } stats_t;

    stats_t        exp_stats[$];
    logic [DW-1:0] exp_rd[$];
    int            checks = 0;
    int            errors = 0;
    int            vec[N];
    int            ref_sorted[N];
    int            ref_sw, ref_pc;
    logic          rd_req = 1'b0, rd_vld_q = 1'b0, done_prev = 1'b0;

    // Monitor: read data is valid one edge after the request; stats when done rises.
    always @(posedge clk) rd_vld_q <= rd_req;

    always @(negedge clk) begin
        if (rd_vld_q) begin
            checks++;
            if (exp_rd.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected got=%0d", rd_data);
            end else begin
                logic [DW-1:0] e;
                e = exp_rd.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data got=%0d exp=%0d", rd_data, e);
                end
            end
        end
        if (done && !done_prev) begin
            checks++;
            if (exp_stats.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected swap_cnt=%0d", swap_cnt);
            end else begin
                stats_t s;
                s = exp_stats.pop_front();
                if (swap_cnt !== s.sw || pass_cnt !== s.pc) begin
                    errors++;
                    $display("FAIL stats swap_cnt=%0d pass_cnt=%0d exp %0d %0d",
                             swap_cnt, pass_cnt, s.sw, s.pc);
                end
            end
        end
        done_prev <= done;
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic load();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'(vec[i]);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic push_stats(input int sw, input int pc);
        stats_t s;
        s.sw = CW'(sw);
        s.pc = (AW+1)'(pc);
        exp_stats.push_back(s);
    endtask

    // Pulse start and return the edge count to done, counting the accept edge as 1.
    task automatic run_sort(input logic d, output int cycles);
        @(negedge clk);
        start = 1'b1; descend = d;
        @(posedge clk);
        cycles = 1;
        #1 start = 1'b0;
        while (!done && cycles < 5000) begin
            @(posedge clk);
            cycles++;
            #1;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic readback();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            rd_addr = AW'(i); rd_req = 1'b1;
            exp_rd.push_back(DW'(ref_sorted[i]));
        end
        @(negedge clk);
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Bubble sort with early exit; result in ref_sorted, counts in ref_sw/ref_pc.
    task automatic model(input logic d);
        int lim, t;
        bit sw_any;
        for (int i = 0; i < N; i++) ref_sorted[i] = vec[i];
        ref_sw = 0; ref_pc = 0; lim = N - 2;
        forever begin
            sw_any = 0;
            for (int k = 0; k <= lim; k++) begin
                if (d ? (ref_sorted[k] < ref_sorted[k+1]) : (ref_sorted[k] > ref_sorted[k+1])) begin
                    t = ref_sorted[k]; ref_sorted[k] = ref_sorted[k+1]; ref_sorted[k+1] = t;
                    ref_sw++; sw_any = 1;
                end
            end
            ref_pc++;
            if (!sw_any || lim == 0) break;
            lim--;
        end
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_swap_cnt", swap_cnt, 0);
        check("rst_pass_cnt", pass_cnt, 0);
        check("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;

        // Already sorted ascending: one pass, 15 compares x 3 + PEND
        for (int i = 0; i < N; i++) vec[i] = i;
        load();
        for (int i = 0; i < N; i++) ref_sorted[i] = i;
        push_stats(0, 1);
        run_sort(1'b0, cyc);
        check("sorted_latency", cyc, 47);
        readback();

        // Reverse order ascending
        for (int i = 0; i < N; i++) vec[i] = N - 1 - i;
        load();
        for (int i = 0; i < N; i++) ref_sorted[i] = i;
        push_stats(120, 15);
        run_sort(1'b0, cyc);
        readback();

        // 0..15 descending, then re-sort already descending array
        for (int i = 0; i < N; i++) vec[i] = i;
        load();
        for (int i = 0; i < N; i++) ref_sorted[i] = N - 1 - i;
        push_stats(120, 15);
        run_sort(1'b1, cyc);
        readback();
        push_stats(0, 1);
        run_sort(1'b1, cyc);
        readback();

        // Duplicates 5,3,5,3...: 36 inversions, 8 swapping passes + 1 clean pass
        for (int i = 0; i < N; i++) vec[i] = (i % 2 == 0) ? 5 : 3;
        load();
        for (int i = 0; i < N; i++) ref_sorted[i] = (i < 8) ? 3 : 5;
        push_stats(36, 9);
        run_sort(1'b0, cyc);
        readback();

        // Random arrays against the reference model
        for (int r = 0; r < 40; r++) begin
            logic d;
            d = r[0];
            for (int i = 0; i < N; i++)
                vec[i] = (r < 20) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 255));
            load();
            model(d);
            push_stats(ref_sw, ref_pc);
            run_sort(d, cyc);
            readback();
        end

        // Writes and start while busy are ignored
        for (int i = 0; i < N; i++) vec[i] = N - 1 - i;
        load();
        for (int i = 0; i < N; i++) ref_sorted[i] = i;
        push_stats(120, 15);
        @(negedge clk);
        start = 1'b1; descend = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        wr_en = 1'b1; wr_addr = '0; wr_data = 8'hAA;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("busy_done_reached", done, 1);
        readback();

        // Start held high through DONE: one sort only, stays in DONE
        for (int i = 0; i < N; i++) vec[i] = N - 1 - i;
        load();
        push_stats(120, 15);
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (20) @(negedge clk);
        check("hold_done", done, 1);
        check("hold_busy", busy, 0);
        check("hold_swap_cnt", swap_cnt, 120);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("release_done", done, 0);
        check("release_busy", busy, 0);

        // Asynchronous reset during the first SWP cycle
        for (int i = 0; i < N; i++) vec[i] = N - 1 - i;
        load();
        @(negedge clk);
        start = 1'b1; descend = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("swp_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_swap_cnt", swap_cnt, 0);
        check("arst_pass_cnt", pass_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) vec[i] = (i * 7) % N;
        load();
        model(1'b0);
        push_stats(ref_sw, ref_pc);
        run_sort(1'b0, cyc);
        readback();

        repeat (4) @(negedge clk);
        check("stats_queue_empty", exp_stats.size(), 0);
        check("rd_queue_empty", exp_rd.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
